// File: rtl/pipe_stall_flush_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_stall_flush_ctrl_if
//
// Purpose : bundles every signal exchanged between the central pipeline
//           controller and the six pipeline stages (IF, ID, EX, MEM1, MEM2,
//           WB) of the MIPS core.
//
// Signals :
//   stallreq_if/id/ex/mem1/mem2  per-stage stall requests        (stage -> ctrl)
//   except_valid, except_is_eret commit-point exception / eret   (stage -> ctrl)
//   cp0_epc[31:0]                EPC used as eret target          (stage -> ctrl)
//   inst_req_pending             fetch accepted, data outstanding (stage -> ctrl)
//   inst_data_ok                 fetch response beat              (stage -> ctrl)
//   stall_<a>_<b>[1:0]           {upstream held, downstream held} (ctrl -> stage)
//   stall_pc                     PC register hold                 (ctrl -> stage)
//   flush, flush_pc[31:0]        pipeline clear + redirect target (ctrl -> stage)
//   fetch_discard                IF drops the next response beat  (ctrl -> stage)
//   perf_stall_cycles[PERF_W-1:0] stall-cycle performance counter (ctrl -> stage)
//
// Modports: master = controller side, slave = pipeline side.
// ----------------------------------------------------------------------------
interface pipe_stall_flush_ctrl_if #(
    parameter int PERF_W = 32
);
    // Stage -> controller
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem1;
    logic              stallreq_mem2;
    logic              except_valid;
    logic              except_is_eret;
    logic [31:0]       cp0_epc;
    logic              inst_req_pending;
    logic              inst_data_ok;

    // Controller -> stage
    logic [1:0]        stall_if_id;
    logic [1:0]        stall_id_ex;
    logic [1:0]        stall_ex_mem1;
    logic [1:0]        stall_mem1_mem2;
    logic [1:0]        stall_mem2_wb;
    logic              stall_pc;
    logic              flush;
    logic [31:0]       flush_pc;
    logic              fetch_discard;
    logic [PERF_W-1:0] perf_stall_cycles;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem1, stallreq_mem2,
        input  except_valid, except_is_eret, cp0_epc,
        input  inst_req_pending, inst_data_ok,
        output stall_if_id, stall_id_ex, stall_ex_mem1, stall_mem1_mem2, stall_mem2_wb,
        output stall_pc, flush, flush_pc, fetch_discard, perf_stall_cycles
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem1, stallreq_mem2,
        output except_valid, except_is_eret, cp0_epc,
        output inst_req_pending, inst_data_ok,
        input  stall_if_id, stall_id_ex, stall_ex_mem1, stall_mem1_mem2, stall_mem2_wb,
        input  stall_pc, flush, flush_pc, fetch_discard, perf_stall_cycles
    );
endinterface

// File: rtl/pipe_stall_flush_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_flush_ctrl
//
// Purpose : central stall / flush controller for the six-stage MIPS pipeline
//           (IF, ID, EX, MEM1, MEM2, WB).
//           - Turns per-stage stall requests into a prefix stall vector: the
//             most downstream requester and everything upstream of it hold.
//           - On a committed exception or eret, lets the faulting MEM2 entry
//             retire, then pulses flush for one cycle with the redirect PC.
//           - If a fetch was in flight when the flush happened, holds IF/PC in
//             DRAIN and tells IF to drop the stale response beat.
//           - Counts cycles in which any stall or flush recovery is active.
//
// Ports   :
//   clk      clock
//   resetn   synchronous, active-low reset
//   ctrl     pipe_stall_flush_ctrl_if.master (all request/stall/flush signals)
//
// Parameters:
//   EXC_VECTOR  redirect target for every exception except eret
//   PERF_W      width of perf_stall_cycles (must match the interface PERF_W)
// ----------------------------------------------------------------------------
module pipe_stall_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          PERF_W     = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    pipe_stall_flush_ctrl_if.master        ctrl
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;

    logic [4:0]        req;          // index 0 = IF ... 4 = MEM2
    logic [5:0]        s_raw;        // prefix vector from requests alone
    logic [5:0]        s_eff;        // vector actually driven onto the buses
    logic              flush_o;
    logic              fetch_discard_o;

    logic [31:0]       flush_pc_q;
    logic              pend_q;       // fetch was outstanding when exception hit
    logic [PERF_W-1:0] perf_q;

    logic              take_exc;
    logic              perf_inc;

    assign req = {ctrl.stallreq_mem2, ctrl.stallreq_mem1, ctrl.stallreq_ex,
                  ctrl.stallreq_id,   ctrl.stallreq_if};

    // Stage i stalls when it or any stage downstream of it requests a stall,
    // so the vector is always a contiguous run of ones starting at IF.
    // WB has nowhere to be held against, so s_raw[5] is tied low.
    assign s_raw[5] = 1'b0;
    assign s_raw[4] = req[4];
    assign s_raw[3] = req[4] | req[3];
    assign s_raw[2] = req[4] | req[3] | req[2];
    assign s_raw[1] = req[4] | req[3] | req[2] | req[1];
    assign s_raw[0] = req[4] | req[3] | req[2] | req[1] | req[0];

    // Exceptions are only accepted in RUN; in FLUSH/DRAIN the pipeline is
    // already empty, so a late except_valid has nothing left to squash.
    assign take_exc = (state_q == RUN) && ctrl.except_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that skips the assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (ctrl.except_valid) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // A fetch outstanding at capture time, or one issued since,
                // will return stale data; wait for it unless it is arriving
                // right now.
                if ((pend_q || ctrl.inst_req_pending) && !ctrl.inst_data_ok) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (ctrl.inst_data_ok) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        s_eff           = '0;
        flush_o         = 1'b0;
        fetch_discard_o = 1'b0;
        unique case (state_q)
            RUN: begin
                // The exception overrides all stall requests so the faulting
                // MEM2 entry retires this cycle.
                if (!ctrl.except_valid) begin
                    s_eff = s_raw;
                end
            end
            FLUSH: begin
                // All buses advance and PC is free to load flush_pc.
                flush_o = 1'b1;
            end
            DRAIN: begin
                // IF/PC hold while the stale beat is dropped; the remaining
                // stages run the normal prefix rule on top of that.
                s_eff           = s_raw | 6'b000001;
                fetch_discard_o = 1'b1;
            end
            default: begin
                s_eff = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Redirect capture and fetch-pending flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flush_pc_q <= 32'h0;
            pend_q     <= 1'b0;
        end else if (take_exc) begin
            flush_pc_q <= ctrl.except_is_eret ? ctrl.cp0_epc : EXC_VECTOR;
            pend_q     <= ctrl.inst_req_pending && !ctrl.inst_data_ok;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle performance counter (wraps naturally; flush leaves it)
    // ------------------------------------------------------------------
    assign perf_inc = (|s_eff) || (state_q != RUN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if (perf_inc) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output mapping: stall_<a>_<b> = {s[a], s[b]}
    // ------------------------------------------------------------------
    assign ctrl.stall_if_id       = {s_eff[0], s_eff[1]};
    assign ctrl.stall_id_ex       = {s_eff[1], s_eff[2]};
    assign ctrl.stall_ex_mem1     = {s_eff[2], s_eff[3]};
    assign ctrl.stall_mem1_mem2   = {s_eff[3], s_eff[4]};
    assign ctrl.stall_mem2_wb     = {s_eff[4], s_eff[5]};
    assign ctrl.stall_pc          = s_eff[0];
    assign ctrl.flush             = flush_o;
    assign ctrl.flush_pc          = flush_pc_q;
    assign ctrl.fetch_discard     = fetch_discard_o;
    assign ctrl.perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_flush_ctrl
//
// Directed test bench for pipe_stall_flush_ctrl. PERF_W is reduced to 8 so
// the counter wrap can be reached in a few hundred cycles.
// The five stall buses are viewed as one 10-bit word:
//   {if_id, id_ex, ex_mem1, mem1_mem2, mem2_wb}
// ----------------------------------------------------------------------------
module tb_pipe_stall_flush_ctrl;

    localparam int PERF_W = 8;

    logic clk;
    logic resetn;

    int checks;
    int errors;

    pipe_stall_flush_ctrl_if #(.PERF_W(PERF_W)) bus ();

    pipe_stall_flush_ctrl #(
        .EXC_VECTOR (32'hBFC00380),
        .PERF_W     (PERF_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .ctrl   (bus.master)
    );

    logic [9:0] stall_all;
    assign stall_all = {bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem1,
                        bus.stall_mem1_mem2, bus.stall_mem2_wb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit
    // after the rising edge, well away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stallreq_if      = 1'b0;
        bus.stallreq_id      = 1'b0;
        bus.stallreq_ex      = 1'b0;
        bus.stallreq_mem1    = 1'b0;
        bus.stallreq_mem2    = 1'b0;
        bus.except_valid     = 1'b0;
        bus.except_is_eret   = 1'b0;
        bus.cp0_epc          = 32'h0;
        bus.inst_req_pending = 1'b0;
        bus.inst_data_ok     = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        #1;
        checks++; if (stall_all !== 10'b0) begin errors++; $display("FAIL reset_buses: got %b expected %b", stall_all, 10'b0); end
        checks++; if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL reset_stall_pc: got %b expected 0", bus.stall_pc); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.flush); end
        checks++; if (bus.flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush_pc: got %h expected 00000000", bus.flush_pc); end
        checks++; if (bus.fetch_discard !== 1'b0) begin errors++; $display("FAIL reset_fetch_discard: got %b expected 0", bus.fetch_discard); end
        checks++; if (bus.perf_stall_cycles !== 8'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", bus.perf_stall_cycles); end
    endtask

    task automatic test_ex_stall();
        bus.stallreq_ex = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stall_all !== 10'b11_11_10_00_00) begin errors++; $display("FAIL ex_stall_buses[%0d]: got %b expected %b", c, stall_all, 10'b11_11_10_00_00); end
            checks++; if (bus.stall_pc !== 1'b1) begin errors++; $display("FAIL ex_stall_pc[%0d]: got %b expected 1", c, bus.stall_pc); end
            step();
        end
        bus.stallreq_ex = 1'b0;
        #1;
        checks++; if (bus.perf_stall_cycles !== 8'd3) begin errors++; $display("FAIL ex_stall_perf: got %0d expected 3", bus.perf_stall_cycles); end
        checks++; if (stall_all !== 10'b0) begin errors++; $display("FAIL ex_stall_release: got %b expected %b", stall_all, 10'b0); end
    endtask

    task automatic test_multi_req();
        bus.stallreq_id   = 1'b1;
        bus.stallreq_mem2 = 1'b1;
        #1;
        checks++; if (stall_all !== 10'b11_11_11_11_10) begin errors++; $display("FAIL id_mem2_buses: got %b expected %b", stall_all, 10'b11_11_11_11_10); end
        bus.stallreq_id   = 1'b0;
        bus.stallreq_mem2 = 1'b0;
        bus.stallreq_if   = 1'b1;
        #1;
        checks++; if (stall_all !== 10'b10_00_00_00_00) begin errors++; $display("FAIL if_only_buses: got %b expected %b", stall_all, 10'b10_00_00_00_00); end
        bus.stallreq_mem1 = 1'b1;
        #1;
        checks++; if (stall_all !== 10'b11_11_11_10_00) begin errors++; $display("FAIL if_mem1_buses: got %b expected %b", stall_all, 10'b11_11_11_10_00); end
        bus.stallreq_if   = 1'b0;
        bus.stallreq_mem1 = 1'b0;
        step();
    endtask

    task automatic test_exc_vector();
        bus.except_valid = 1'b1;
        bus.except_is_eret = 1'b0;
        bus.cp0_epc = 32'h12345678;
        step();
        bus.except_valid = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL exc_flush: got %b expected 1", bus.flush); end
        checks++; if (bus.flush_pc !== 32'hBFC00380) begin errors++; $display("FAIL exc_flush_pc: got %h expected bfc00380", bus.flush_pc); end
        checks++; if ({stall_all, bus.stall_pc} !== 11'b0) begin errors++; $display("FAIL exc_flush_buses: got %b expected %b", {stall_all, bus.stall_pc}, 11'b0); end
        checks++; if (bus.fetch_discard !== 1'b0) begin errors++; $display("FAIL exc_flush_discard: got %b expected 0", bus.fetch_discard); end
        step();
        checks++; if ({bus.flush, bus.fetch_discard} !== 2'b00) begin errors++; $display("FAIL exc_back_to_run: got %b expected 00", {bus.flush, bus.fetch_discard}); end
    endtask

    task automatic test_eret_drain();
        bus.except_valid     = 1'b1;
        bus.except_is_eret   = 1'b1;
        bus.cp0_epc          = 32'h80001234;
        bus.inst_req_pending = 1'b1;
        step();
        bus.except_valid   = 1'b0;
        bus.except_is_eret = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL eret_flush: got %b expected 1", bus.flush); end
        checks++; if (bus.flush_pc !== 32'h80001234) begin errors++; $display("FAIL eret_flush_pc: got %h expected 80001234", bus.flush_pc); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({bus.flush, bus.fetch_discard, bus.stall_pc} !== 3'b011) begin errors++; $display("FAIL eret_drain[%0d]: flush/discard/stall_pc got %b expected 011", c, {bus.flush, bus.fetch_discard, bus.stall_pc}); end
            checks++; if (stall_all !== 10'b10_00_00_00_00) begin errors++; $display("FAIL eret_drain_buses[%0d]: got %b expected %b", c, stall_all, 10'b10_00_00_00_00); end
        end
        bus.inst_data_ok = 1'b1;
        #1;
        checks++; if (bus.fetch_discard !== 1'b1) begin errors++; $display("FAIL eret_beat_discard: got %b expected 1", bus.fetch_discard); end
        step();
        bus.inst_data_ok     = 1'b0;
        bus.inst_req_pending = 1'b0;
        #1;
        checks++; if ({bus.fetch_discard, bus.stall_pc, bus.flush} !== 3'b000) begin errors++; $display("FAIL eret_back_to_run: got %b expected 000", {bus.fetch_discard, bus.stall_pc, bus.flush}); end
        checks++; if (bus.flush_pc !== 32'h80001234) begin errors++; $display("FAIL eret_flush_pc_hold: got %h expected 80001234", bus.flush_pc); end
    endtask

    task automatic test_exc_with_stall();
        bus.stallreq_mem1    = 1'b1;
        bus.except_valid     = 1'b1;
        bus.inst_req_pending = 1'b1;
        #1;
        checks++; if ({stall_all, bus.stall_pc} !== 11'b0) begin errors++; $display("FAIL exc_stall_override: got %b expected %b", {stall_all, bus.stall_pc}, 11'b0); end
        step();
        bus.except_valid = 1'b0;
        #1;
        checks++; if ({bus.flush, stall_all} !== {1'b1, 10'b0}) begin errors++; $display("FAIL exc_stall_flush: got %b expected %b", {bus.flush, stall_all}, {1'b1, 10'b0}); end
        step();
        checks++; if (stall_all !== 10'b11_11_11_10_00) begin errors++; $display("FAIL exc_stall_drain_buses: got %b expected %b", stall_all, 10'b11_11_11_10_00); end
        checks++; if ({bus.flush, bus.fetch_discard} !== 2'b01) begin errors++; $display("FAIL exc_stall_drain: got %b expected 01", {bus.flush, bus.fetch_discard}); end
        // A second exception while draining must be ignored.
        bus.except_valid   = 1'b1;
        bus.except_is_eret = 1'b1;
        bus.cp0_epc        = 32'hDEADBEEC;
        step();
        bus.except_valid   = 1'b0;
        bus.except_is_eret = 1'b0;
        #1;
        checks++; if ({bus.flush, bus.fetch_discard} !== 2'b01) begin errors++; $display("FAIL exc_in_drain_ignored: got %b expected 01", {bus.flush, bus.fetch_discard}); end
        checks++; if (bus.flush_pc !== 32'hBFC00380) begin errors++; $display("FAIL exc_in_drain_pc: got %h expected bfc00380", bus.flush_pc); end
        step();
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL exc_in_drain_no_flush: got %b expected 0", bus.flush); end
        bus.stallreq_mem1    = 1'b0;
        bus.inst_data_ok     = 1'b1;
        step();
        bus.inst_data_ok     = 1'b0;
        bus.inst_req_pending = 1'b0;
        #1;
        checks++; if ({bus.flush, bus.fetch_discard, stall_all} !== 12'b0) begin errors++; $display("FAIL exc_stall_recovered: got %b expected %b", {bus.flush, bus.fetch_discard, stall_all}, 12'b0); end
    endtask

    task automatic test_wrap_and_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        checks++; if (bus.perf_stall_cycles !== 8'd0) begin errors++; $display("FAIL wrap_start: got %0d expected 0", bus.perf_stall_cycles); end
        bus.stallreq_if = 1'b1;
        repeat (255) step();
        checks++; if (bus.perf_stall_cycles !== 8'd255) begin errors++; $display("FAIL wrap_max: got %0d expected 255", bus.perf_stall_cycles); end
        step();
        checks++; if (bus.perf_stall_cycles !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", bus.perf_stall_cycles); end
        bus.stallreq_if = 1'b0;

        // Reach DRAIN, then reset mid-recovery.
        bus.except_valid     = 1'b1;
        bus.inst_req_pending = 1'b1;
        step();
        bus.except_valid = 1'b0;
        step();
        checks++; if (bus.fetch_discard !== 1'b1) begin errors++; $display("FAIL pre_reset_drain: got %b expected 1", bus.fetch_discard); end
        resetn = 1'b0;
        bus.inst_req_pending = 1'b0;
        step();
        checks++; if ({bus.flush, bus.fetch_discard, bus.stall_pc, stall_all} !== 13'b0) begin errors++; $display("FAIL reset_in_drain_ctrl: got %b expected %b", {bus.flush, bus.fetch_discard, bus.stall_pc, stall_all}, 13'b0); end
        checks++; if (bus.flush_pc !== 32'h0) begin errors++; $display("FAIL reset_in_drain_pc: got %h expected 00000000", bus.flush_pc); end
        checks++; if (bus.perf_stall_cycles !== 8'd0) begin errors++; $display("FAIL reset_in_drain_perf: got %0d expected 0", bus.perf_stall_cycles); end
        resetn = 1'b1;
        step();
        checks++; if ({bus.flush, bus.fetch_discard} !== 2'b00) begin errors++; $display("FAIL post_reset_no_flush: got %b expected 00", {bus.flush, bus.fetch_discard}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_ex_stall();
        test_multi_req();
        test_exc_vector();
        test_eret_drain();
        test_exc_with_stall();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
